// File: rtl/instr_pack.sv
// instr_pack: types and constants shared by the fetch and decode stages
package instr_pack;
  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state;
  typedef enum logic [2:0] {
    BR_NONE, BR_Z, BR_NZ, BR_JMP, BR_ABS, BR_RSV5, BR_RSV6, BR_RSV7
  } branch_code;
  localparam logic [8:0] NOP_INSTR = 9'h160;
endpackage

// File: rtl/branch_target.sv
// branch_target: decides whether a branch is taken and where it goes
module branch_target
  import instr_pack::*;
#(
  parameter int PC_W = 10
) (
  input  logic [PC_W-1:0] instr_pc,
  input  logic [PC_W-1:0] br_off,
  input  branch_code      branch,
  input  logic            zero_i,
  output logic            taken,
  output logic [PC_W-1:0] target
);
  // reserved codes fall through as not taken; relative targets wrap at PC_W bits
  always_comb begin
    taken  = (branch == BR_Z && zero_i) || (branch == BR_NZ && !zero_i) ||
             branch == BR_JMP || branch == BR_ABS;
    target = (branch == BR_ABS) ? br_off : instr_pc + br_off;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction memory addressing and run control
module fetch_unit
  import instr_pack::*;
#(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             done_i,
  input  branch_code       branch,
  input  logic             zero_i,
  input  logic [PC_W-1:0]  br_off,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [8:0]       imem_data,
  output logic [8:0]       instr,
  output logic             instr_valid,
  output logic [PC_W-1:0]  instr_pc,
  output logic             done,
  output logic [CNT_W-1:0] retired
);
  fetch_state       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d, instr_pc_q, instr_pc_d, target;
  logic             valid_q, valid_d, taken;
  logic [CNT_W-1:0] retired_q, retired_d;

  branch_target #(.PC_W(PC_W)) u_branch_target (
    .instr_pc(instr_pc_q),
    .br_off  (br_off),
    .branch  (branch),
    .zero_i  (zero_i),
    .taken   (taken),
    .target  (target)
  );

  // next-state: start from IDLE/HALT, stream in RUN, halt beats branch, taken branch squashes
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    valid_d    = 1'b0;
    retired_d  = retired_q;
    if (state_q != RUN) begin
      if (start) begin
        state_d   = RUN;
        pc_d      = '0;
        retired_d = '0;
      end
    end else begin
      instr_pc_d = pc_q;
      valid_d    = 1'b1;
      pc_d       = pc_q + PC_W'(1);
      if (valid_q) begin
        retired_d = (&retired_q) ? retired_q : retired_q + CNT_W'(1);
        if (done_i) begin
          state_d = HALT;
          valid_d = 1'b0;
          pc_d    = pc_q;
        end else if (taken) begin
          pc_d    = target;
          valid_d = 1'b0;
        end
      end
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      retired_q  <= retired_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = valid_q ? imem_data : NOP_INSTR;
  assign instr_valid = valid_q;
  assign instr_pc    = instr_pc_q;
  assign done        = (state_q == HALT);
  assign retired     = retired_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: program-trace model of fetch checked against the DUT every cycle
module tb_fetch_unit;
  import instr_pack::*;

  typedef struct {
    bit         v;
    logic [9:0] pc;
  } ent_t;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, done_i = 1'b0, zero_i = 1'b0;
  branch_code  br = BR_NONE;
  logic [9:0]  br_off = '0, imem_addr, instr_pc;
  logic [8:0]  imem_data = '0, instr;
  logic        instr_valid, done;
  logic [15:0] retired;

  logic [8:0]  mem[1024];
  logic [2:0]  br_t[1024];
  logic [9:0]  off_t[1024];
  bit          z_t[1024], dn_t[1024];
  ent_t        q[$];

  int tests = 0, fails = 0;
  bit chk_en = 1'b0, e_valid, pc_en, e_done, addr_en;
  logic [9:0] e_pc, e_addr;
  int e_ret;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(10), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done_i(done_i), .branch(br),
    .zero_i(zero_i), .br_off(br_off), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc), .done(done),
    .retired(retired)
  );

  always @(posedge clk) imem_data <= mem[imem_addr];

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("instr_valid", 32'(instr_valid), 32'(e_valid));
      chk("instr", 32'(instr), e_valid ? 32'(mem[e_pc]) : 32'(NOP_INSTR));
      if (pc_en) chk("instr_pc", 32'(instr_pc), 32'(e_pc));
      chk("done", 32'(done), 32'(e_done));
      chk("retired", 32'(retired), 32'(e_ret));
      if (addr_en) chk("imem_addr", 32'(imem_addr), 32'(e_addr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_set(bit v, logic [9:0] pc, bit pe, bit d, int r, bit ae, logic [9:0] a);
    e_valid = v; e_pc = pc; pc_en = pe; e_done = d; e_ret = r; addr_en = ae; e_addr = a;
  endtask

  task automatic garbage();
    done_i = 1'($urandom);
    br     = branch_code'(3'($urandom));
    zero_i = 1'($urandom);
    br_off = 10'($urandom);
  endtask

  task automatic clr();
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 9'($urandom); br_t[i] = '0; off_t[i] = '0; z_t[i] = 1'b0; dn_t[i] = 1'b0;
    end
  endtask

  task automatic rnd_tables();
    for (int i = 0; i < 1024; i++) begin
      mem[i]   = 9'($urandom);
      br_t[i]  = 3'($urandom);
      off_t[i] = ($urandom % 4 == 0) ? 10'($urandom) : 10'($urandom_range(0, 32)) - 10'd16;
      z_t[i]   = 1'($urandom);
      dn_t[i]  = ($urandom % 50 == 0);
    end
  endtask

  // program-level trace: each presented address, with one bubble after every taken branch
  task automatic build(int lim);
    logic [9:0] p, tgt;
    bit tk;
    int n;
    q.delete();
    q.push_back('{1'b0, 10'd0});
    p = '0;
    n = 0;
    while (1) begin
      q.push_back('{1'b1, p});
      n++;
      if (dn_t[p] || n >= lim) break;
      case (br_t[p])
        3'd1: tk = z_t[p];
        3'd2: tk = !z_t[p];
        3'd3, 3'd4: tk = 1'b1;
        default: tk = 1'b0;
      endcase
      tgt = (br_t[p] == 3'd4) ? off_t[p] : p + off_t[p];
      if (tk) begin
        q.push_back('{1'b0, 10'd0});
        p = tgt;
      end else p = p + 10'd1;
    end
  endtask

  task automatic run_prog(int lim, int abort_at, output int nret);
    int r;
    build(lim);
    step();
    start = 1'b1;
    garbage();
    r = 0;
    nret = 0;
    for (int i = 0; i < q.size(); i++) begin
      step();
      start = ($urandom % 5 == 0);
      if (i == abort_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        exp_set(0, 10'd0, 1, 0, 0, 1, 10'd0);
        step();
        rst_n = 1'b1;
        return;
      end
      if (q[i].v) begin
        br     = branch_code'(br_t[q[i].pc]);
        zero_i = z_t[q[i].pc];
        br_off = off_t[q[i].pc];
        done_i = dn_t[q[i].pc] || (i == q.size() - 1);
      end else garbage();
      exp_set(q[i].v, q[i].pc, q[i].v, 0, r, i == 0, 10'd0);
      r += int'(q[i].v);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      start = 1'b0;
      garbage();
      exp_set(0, 10'd0, 0, 1, r, 1, q[q.size() - 1].pc + 10'd1);
    end
    nret = r;
  endtask

  initial begin
    int n;
    clr();
    exp_set(0, 10'd0, 1, 0, 0, 1, 10'd0);
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    // straight-line program halting at address 4
    clr();
    for (int i = 0; i < 5; i++) mem[i] = 9'(i + 1);
    dn_t[4] = 1'b1;
    run_prog(100, -1, n);
    chk("s1_model_count", 32'(n), 32'd5);
    chk("s1_model_len", 32'(q.size()), 32'd6);
    chk("s1_retired", 32'(retired), 32'd5);
    chk("s1_done", 32'(done), 32'd1);
    // conditional-on-zero back branch, taken
    clr();
    br_t[3] = 3'd1; z_t[3] = 1'b1; off_t[3] = 10'h3FE;
    run_prog(8, -1, n);
    chk("s2_model_bubble", 32'(q[5].v), 32'd0);
    chk("s2_model_target", 32'(q[6].pc), 32'd1);
    // same branch not taken
    z_t[3] = 1'b0; dn_t[6] = 1'b1;
    run_prog(100, -1, n);
    chk("s2b_model_fall", 32'(q[5].pc), 32'd4);
    chk("s2b_model_valid", 32'(q[5].v), 32'd1);
    // absolute branch to the top of memory and wrap to 0
    clr();
    br_t[2] = 3'd4; off_t[2] = 10'h3FF;
    run_prog(7, -1, n);
    chk("s3_model_bubble", 32'(q[4].v), 32'd0);
    chk("s3_model_abs", 32'(q[5].pc), 32'h3FF);
    chk("s3_model_wrap", 32'(q[6].pc), 32'h000);
    // halt wins over an unconditional branch on the same instruction
    clr();
    dn_t[2] = 1'b1; br_t[2] = 3'd3; off_t[2] = 10'd5;
    run_prog(100, -1, n);
    chk("s4_model_len", 32'(q.size()), 32'd4);
    chk("s4_retired", 32'(retired), 32'd3);
    chk("s4_imem_addr", 32'(imem_addr), 32'd3);
    // reset mid-run, then a clean restart
    rnd_tables();
    run_prog(50, 4, n);
    clr();
    for (int i = 0; i < 5; i++) mem[i] = 9'(i + 1);
    dn_t[4] = 1'b1;
    run_prog(100, -1, n);
    chk("s5_retired", 32'(retired), 32'd5);
    // random programs, some interrupted by reset
    for (int t = 0; t < 30; t++) begin
      rnd_tables();
      run_prog(1 + int'($urandom % 60), ($urandom % 5 == 0) ? int'($urandom % 12) : -1, n);
    end
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
